// File: rtl/signal_synth_dds.sv
// -----------------------------------------------------------------------------
// signal_synth_dds
//   Single-clock DDS tone generator with per-key tuning words, four waveforms
//   (sine, square, saw, triangle) and an attack/sustain/release envelope.
//   Output is an unsigned sample stream centred at midscale.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   keys         key-held levels (synchronous to clk); lowest index wins
//   mode         waveform select: 0 sine, 1 square, 2 saw, 3 triangle
//   tune_we      tuning write strobe; single-cycle, no handshake: the write
//                is accepted in every cycle it is high with an in-range index
//   tune_idx     key index to write (out-of-range indices are ignored)
//   tune_data    new tuning word
//   signal       output sample (2 cycles behind the phase register)
//   note_active  high whenever the envelope is not idle
//   note_idx     index of the sounding key
//   o_dbg_state  envelope FSM state
//   o_dbg_env    envelope level (0 .. 2^ENV_W)
//   o_dbg_phase  phase accumulator
// -----------------------------------------------------------------------------
module signal_synth_dds #(
  parameter int NUM_KEYS   = 9,
  parameter int OUT_W      = 8,
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 6,
  parameter int BASE_INC   = 64,
  parameter int ENV_W      = 8,
  parameter int ENV_DIV    = 256,
  localparam int IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          mode,
  input  logic                tune_we,
  input  logic [IDX_W-1:0]    tune_idx,
  input  logic [PHASE_W-1:0]  tune_data,
  output logic [OUT_W-1:0]    signal,
  output logic                note_active,
  output logic [IDX_W-1:0]    note_idx,
  output logic [1:0]          o_dbg_state,
  output logic [ENV_W:0]      o_dbg_env,
  output logic [PHASE_W-1:0]  o_dbg_phase
);

  localparam int PRE_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int PW    = OUT_W + ENV_W + 2;
  localparam int MID   = 2 ** (OUT_W - 1);
  localparam logic [ENV_W:0] ENV_MAX = {1'b1, {ENV_W{1'b0}}};

  // Full-wave sine table, round(127.5*(1+sin(2*pi*i/64))), built for the
  // default 8-bit sample / 6-bit address configuration.
  localparam logic [7:0] SINE_TAB [64] = '{
    8'd128, 8'd140, 8'd152, 8'd165, 8'd176, 8'd188, 8'd198, 8'd208,
    8'd218, 8'd226, 8'd234, 8'd240, 8'd245, 8'd250, 8'd253, 8'd254,
    8'd255, 8'd254, 8'd253, 8'd250, 8'd245, 8'd240, 8'd234, 8'd226,
    8'd218, 8'd208, 8'd198, 8'd188, 8'd176, 8'd165, 8'd152, 8'd140,
    8'd128, 8'd115, 8'd103, 8'd90,  8'd79,  8'd67,  8'd57,  8'd47,
    8'd37,  8'd29,  8'd21,  8'd15,  8'd10,  8'd5,   8'd2,   8'd1,
    8'd0,   8'd1,   8'd2,   8'd5,   8'd10,  8'd15,  8'd21,  8'd29,
    8'd37,  8'd47,  8'd57,  8'd67,  8'd79,  8'd90,  8'd103, 8'd115
  };

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               r_state, w_state_n;
  logic [ENV_W:0]       r_env, w_env_n;
  logic [PRE_W-1:0]     r_presc;
  logic [PHASE_W-1:0]   r_phase;
  logic [PHASE_W-1:0]   r_tune [NUM_KEYS];
  logic [IDX_W-1:0]     r_note_idx;
  logic [OUT_W-1:0]     r_wave;
  logic [OUT_W-1:0]     r_signal;

  logic                 w_any;
  logic [IDX_W-1:0]     w_win;
  logic                 w_step;
  logic [OUT_W-1:0]     w_p;
  logic [OUT_W-1:0]     w_tri;
  logic [OUT_W-1:0]     w_wave;
  logic signed [OUT_W:0] w_w;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_sum;

  // Lowest-index held key wins; the loop runs high-to-low so the last
  // match (lowest index) sticks.
  assign w_any = |keys;
  always_comb begin
    w_win = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (keys[k]) w_win = IDX_W'(k);
    end
  end

  assign w_step = (r_presc == PRE_W'(ENV_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_step ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_KEYS; k++) r_tune[k] <= PHASE_W'(BASE_INC * (k + 1));
    end else if (tune_we && ({1'b0, tune_idx} < (IDX_W + 1)'(NUM_KEYS))) begin
      r_tune[tune_idx] <= tune_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_note_idx <= '0;
      r_phase    <= '0;
    end else begin
      if (w_any) r_note_idx <= w_win;
      // Idle forces phase to zero so every fresh note starts at phase 0.
      r_phase <= (r_state != S_IDLE) ? r_phase + r_tune[r_note_idx] : '0;
    end
  end

  // Envelope FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_env   <= '0;
    end else begin
      r_state <= w_state_n;
      r_env   <= w_env_n;
    end
  end

  // Envelope FSM: next state / level. Key release beats a same-cycle step,
  // and a re-press during release beats a same-cycle decrement.
  always_comb begin
    w_state_n = r_state;
    w_env_n   = r_env;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_n = S_ATTACK;
      end
      S_ATTACK: begin
        if (!w_any) begin
          w_state_n = S_RELEASE;
        end else if (r_env == ENV_MAX) begin
          w_state_n = S_SUSTAIN;
        end else if (w_step) begin
          w_env_n = r_env + 1'b1;
          if (r_env == ENV_MAX - 1'b1) w_state_n = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (!w_any) w_state_n = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_any) begin
          w_state_n = S_ATTACK;
        end else if (r_env == '0) begin
          w_state_n = S_IDLE;
        end else if (w_step) begin
          w_env_n = r_env - 1'b1;
          if (r_env == {{ENV_W{1'b0}}, 1'b1}) w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Waveform generation from the current phase (stage 1 input)
  assign w_p   = r_phase[PHASE_W-1 -: OUT_W];
  assign w_tri = {w_p[OUT_W-2:0], 1'b0};

  always_comb begin
    w_wave = '0;
    case (mode)
      2'd0: w_wave = OUT_W'(SINE_TAB[r_phase[PHASE_W-1 -: LUT_ADDR_W]]);
      2'd1: w_wave = {OUT_W{~r_phase[PHASE_W-1]}};
      2'd2: w_wave = w_p;
      default: w_wave = r_phase[PHASE_W-1] ? ~w_tri : w_tri;
    endcase
  end

  // Envelope scaling around midscale; the arithmetic shift floors negative
  // products, and env = 2^ENV_W reproduces the wave exactly.
  assign w_w    = $signed({1'b0, r_wave} - (OUT_W + 1)'(MID));
  assign w_prod = PW'(w_w) * PW'($signed({1'b0, r_env}));
  assign w_sum  = (w_prod >>> ENV_W) + PW'(MID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wave   <= OUT_W'(MID);
      r_signal <= OUT_W'(MID);
    end else begin
      r_wave   <= w_wave;
      r_signal <= w_sum[OUT_W-1:0];
    end
  end

  assign signal      = r_signal;
  assign note_active = (r_state != S_IDLE);
  assign note_idx    = r_note_idx;
  assign o_dbg_state = r_state;
  assign o_dbg_env   = r_env;
  assign o_dbg_phase = r_phase;

endmodule

// File: tb/tb_signal_synth_dds.sv
// -----------------------------------------------------------------------------
// tb_signal_synth_dds
//   Two instances (envelope step every cycle, and every 3 cycles) share one
//   stimulus stream and are compared against a behavioural model of the tone
//   generator every cycle.
// -----------------------------------------------------------------------------
module tb_signal_synth_dds;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] keys;
  logic [1:0] mode;
  logic       tune_we;
  logic [3:0] tune_idx;
  logic [15:0] tune_data;

  logic [7:0]  sig  [2];
  logic        act  [2];
  logic [3:0]  nidx [2];
  logic [1:0]  dst  [2];
  logic [8:0]  denv [2];
  logic [15:0] dph  [2];

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  signal_synth_dds #(.ENV_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .keys(keys), .mode(mode), .tune_we(tune_we),
    .tune_idx(tune_idx), .tune_data(tune_data), .signal(sig[0]),
    .note_active(act[0]), .note_idx(nidx[0]), .o_dbg_state(dst[0]),
    .o_dbg_env(denv[0]), .o_dbg_phase(dph[0])
  );

  signal_synth_dds #(.ENV_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .keys(keys), .mode(mode), .tune_we(tune_we),
    .tune_idx(tune_idx), .tune_data(tune_data), .signal(sig[1]),
    .note_active(act[1]), .note_idx(nidx[1]), .o_dbg_state(dst[1]),
    .o_dbg_env(denv[1]), .o_dbg_phase(dph[1])
  );

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 attack, 2 sustain, 3 release
  int m_div [2] = '{1, 3};
  int m_st [2], m_env [2], m_presc [2], m_phase [2], m_nidx [2];
  int m_wave [2], m_sig [2];
  int m_tune [2][9];
  int lut [64];

  function automatic void model_reset(int d);
    m_st[d] = 0; m_env[d] = 0; m_presc[d] = 0; m_phase[d] = 0;
    m_nidx[d] = 0; m_wave[d] = 128; m_sig[d] = 128;
    for (int k = 0; k < 9; k++) m_tune[d][k] = (64 * (k + 1)) % 65536;
  endfunction

  function automatic int wave_of(int md, int ph);
    int p;
    p = ph / 256;
    case (md)
      0: return lut[ph / 1024];
      1: return (ph < 32768) ? 255 : 0;
      2: return p;
      default: return (ph < 32768) ? (2 * p) % 256 : 255 - (2 * p) % 256;
    endcase
  endfunction

  function automatic int scale(int wave, int env);
    int prod;
    prod = (wave - 128) * env;
    if (prod >= 0) return 128 + prod / 256;
    return 128 - ((-prod + 255) / 256);
  endfunction

  function automatic void model_step(int d);
    int win, n_phase, n_nidx, n_presc, n_st, n_env;
    bit any, step;
    any = (keys != 0);
    win = 0;
    for (int i = 8; i >= 0; i--) if (keys[i]) win = i;
    n_phase = (m_st[d] != 0) ? (m_phase[d] + m_tune[d][m_nidx[d]]) % 65536 : 0;
    n_nidx  = any ? win : m_nidx[d];
    step    = (m_presc[d] == m_div[d] - 1);
    n_presc = step ? 0 : m_presc[d] + 1;
    n_st = m_st[d]; n_env = m_env[d];
    if (m_st[d] == 0) begin
      if (any) n_st = 1;
    end else if (m_st[d] == 1) begin
      if (!any) n_st = 3;
      else if (m_env[d] >= 256) n_st = 2;
      else if (step) begin n_env = m_env[d] + 1; if (n_env == 256) n_st = 2; end
    end else if (m_st[d] == 2) begin
      if (!any) n_st = 3;
    end else begin
      if (any) n_st = 1;
      else if (m_env[d] == 0) n_st = 0;
      else if (step) begin n_env = m_env[d] - 1; if (n_env == 0) n_st = 0; end
    end
    m_sig[d]  = scale(m_wave[d], m_env[d]);
    m_wave[d] = wave_of(int'(mode), m_phase[d]);
    if (tune_we && tune_idx < 9) m_tune[d][tune_idx] = int'(tune_data);
    m_phase[d] = n_phase; m_nidx[d] = n_nidx; m_presc[d] = n_presc;
    m_st[d] = n_st; m_env[d] = n_env;
  endfunction

  function automatic logic [37:0] exp_v(int d);
    return {8'(m_sig[d]), (m_st[d] != 0), 4'(m_nidx[d]), 16'(m_phase[d]), 9'(m_env[d])};
  endfunction

  function automatic logic [37:0] obs_v(int d);
    return {sig[d], act[d], nidx[d], dph[d], denv[d]};
  endfunction

  // ---------------- driver ----------------
  // Inputs change only just after a falling edge; the model advances at the
  // rising edge and outputs are sampled at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!reset) model_reset(d); else model_step(d);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; keys = '0; mode = 2'd0; tune_we = 1'b0; tune_idx = '0; tune_data = '0;
    model_reset(0); model_reset(1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_v(d) !== exp_v(d)) begin
        errors++; $display("FAIL reset_state dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
      end
      checks++;
      if (sig[d] !== 8'd128 || act[d] !== 1'b0) begin
        errors++; $display("FAIL reset_mid dut%0d: got sig=%0d act=%0b expected 128/0", d, sig[d], act[d]);
      end
    end
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_saw_attack();
    logic [15:0] p0;
    mode = 2'd2; keys = 9'b000000100;
    repeat (270) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL saw_attack dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    checks++;
    if (denv[0] !== 9'd256 || nidx[0] !== 4'd2) begin
      errors++; $display("FAIL saw_sustain_env: got env=%0d idx=%0d expected 256/2", denv[0], nidx[0]);
    end
    p0 = dph[0];
    cycle();
    checks++;
    if (dph[0] - p0 !== 16'd192) begin
      errors++; $display("FAIL saw_phase_step: got %0d expected 192", dph[0] - p0);
    end
  endtask

  task automatic test_legato();
    int n;
    keys = '0;
    n = 0;
    while (!(m_st[0] == 0 && m_st[1] == 0) && n < 2000) begin
      cycle(); n++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL legato_release dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL legato_idle_timeout: got %0d cycles expected < 2000", n); end
    keys = 9'b000101000;
    for (int c = 0; c < 80; c++) begin
      if (c == 40) begin
        checks++;
        if (nidx[0] !== 4'd3 || denv[0] !== 9'd39) begin
          errors++; $display("FAIL legato_first: got idx=%0d env=%0d expected 3/39", nidx[0], denv[0]);
        end
        keys = 9'b000100000;
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL legato_run dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    checks++;
    if (nidx[0] !== 4'd5 || denv[0] !== 9'd79) begin
      errors++; $display("FAIL legato_change: got idx=%0d env=%0d expected 5/79", nidx[0], denv[0]);
    end
  endtask

  task automatic test_square_sustain();
    int n, high;
    mode = 2'd1; keys = 9'b000000001;
    n = 0;
    while (!(m_st[0] == 2 && m_st[1] == 2) && n < 1500) begin
      cycle(); n++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL square_attack dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    checks++;
    if (n >= 1500) begin errors++; $display("FAIL square_sustain_timeout: got %0d cycles expected < 1500", n); end
    repeat (4) cycle();
    high = 0;
    repeat (1024) begin
      cycle();
      if (sig[0] === 8'd255) high++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL square_sustain dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    checks++;
    if (high != 512) begin errors++; $display("FAIL square_duty: got %0d high cycles expected 512", high); end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b0;
    model_reset(0); model_reset(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sig[d] !== 8'd128 || act[d] !== 1'b0 || dph[d] !== 16'd0 || denv[d] !== 9'd0) begin
        errors++; $display("FAIL async_reset dut%0d: got sig=%0d act=%0b ph=%0d env=%0d expected 128/0/0/0",
                           d, sig[d], act[d], dph[d], denv[d]);
      end
    end
    cycle(); cycle();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c == 1) begin
        checks++;
        if (dph[0] !== 16'd64) begin errors++; $display("FAIL restart_phase: got %0d expected 64", dph[0]); end
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL restart dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
  endtask

  task automatic test_tune();
    logic [15:0] p0;
    tune_we = 1'b1; tune_idx = 4'd0; tune_data = 16'd1000;
    cycle();
    tune_we = 1'b0;
    p0 = dph[0];
    cycle();
    checks++;
    if (dph[0] - p0 !== 16'd1000) begin errors++; $display("FAIL tune_step: got %0d expected 1000", dph[0] - p0); end
    tune_we = 1'b1; tune_idx = 4'd12; tune_data = 16'($urandom_range(65535, 0));
    cycle();
    tune_we = 1'b0;
    p0 = dph[0];
    cycle();
    checks++;
    if (dph[0] - p0 !== 16'd1000) begin errors++; $display("FAIL tune_ignored_idx: got %0d expected 1000", dph[0] - p0); end
    repeat (20) begin
      tune_we = ($urandom_range(3, 0) == 0); tune_idx = 4'($urandom_range(15, 0));
      tune_data = 16'($urandom_range(65535, 0));
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL tune_random dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    tune_we = 1'b0;
  endtask

  task automatic test_release();
    int n;
    mode = 2'd3;
    n = 0;
    while (m_st[0] != 2 && n < 400) begin cycle(); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL release_sustain_timeout: got %0d cycles expected < 400", n); end
    keys = '0;
    n = 0;
    while (!(m_st[0] == 3 && m_env[0] == 100) && n < 400) begin
      cycle(); n++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL release_ramp dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL release_env100_timeout: got %0d cycles expected < 400", n); end
    keys = 9'b000001000;
    repeat (30) cycle();
    checks++;
    if (denv[0] !== 9'd129) begin errors++; $display("FAIL release_repress: got env=%0d expected 129", denv[0]); end
    keys = '0;
    n = 0;
    while (!(m_st[0] == 0 && m_st[1] == 0) && n < 2000) begin
      cycle(); n++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL release_to_idle dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sig[d] !== 8'd128 || act[d] !== 1'b0 || dph[d] !== 16'd0 || denv[d] !== 9'd0) begin
        errors++; $display("FAIL release_idle dut%0d: got sig=%0d act=%0b ph=%0d env=%0d expected 128/0/0/0",
                           d, sig[d], act[d], dph[d], denv[d]);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    repeat (4000) begin
      if (hold == 0) begin
        keys = ($urandom_range(2, 0) == 0) ? 9'd0 : 9'($urandom_range(511, 1));
        mode = 2'($urandom_range(3, 0));
        hold = $urandom_range(60, 1);
      end
      hold--;
      tune_we = ($urandom_range(31, 0) == 0); tune_idx = 4'($urandom_range(15, 0));
      tune_data = 16'($urandom_range(4000, 1));
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_v(d) !== exp_v(d)) begin
          errors++; $display("FAIL random dut%0d: got %h expected %h", d, obs_v(d), exp_v(d));
        end
      end
    end
    tune_we = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 64; i++)
      lut[i] = $rtoi($floor(127.5 * (1.0 + $sin(2.0 * 3.141592653589793 * i / 64.0)) + 0.5));
    test_reset();
    test_saw_attack();
    test_legato();
    test_square_sustain();
    test_async_reset();
    test_tune();
    test_release();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
